// File: rtl/eth_pkg.sv
// Shared types and helpers for the Ethernet UDP transmit path.
package eth_pkg;

  localparam int unsigned UDP_MAX_PAYLOAD = 1472;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StArmed,
    StSend,
    StGap
  } tx_state_e;

  function automatic int unsigned min_len(input int unsigned count, input int unsigned max_val);
    return (count > max_val) ? max_val : count;
  endfunction

endpackage

// File: rtl/batch_timer.sv
// Loadable down-counter; o_done is high while enabled and the count has reached zero.
module batch_timer #(
  parameter int unsigned Width = 17
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/udp_tx_batcher.sv
// Batches TX FIFO bytes into UDP payload announcements and gates FIFO reads to exactly
// the announced length.
module udp_tx_batcher
  import eth_pkg::*;
#(
  parameter int unsigned MaxPayload    = UDP_MAX_PAYLOAD,
  parameter int unsigned MinBatch      = 64,
  parameter int unsigned TimeoutCycles = 125000,
  parameter int unsigned GapCycles     = 16,
  parameter int unsigned CntW          = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [CntW-1:0] i_fifo_count,
  input  logic            i_fifo_empty,
  input  logic [7:0]      i_fifo_dout,
  output logic            o_fifo_rd_en,
  output logic [CntW-1:0] o_udp_tx_pending_data,
  input  logic            i_udp_tx_rden,
  output logic [7:0]      o_udp_tx,
  output logic            o_busy,
  output logic            o_underrun_err,
  output logic            o_overrun_err,
  output logic [15:0]     o_frame_cnt
);

  localparam int unsigned TimerMax = (TimeoutCycles > GapCycles) ? TimeoutCycles : GapCycles;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  tx_state_e         r_state, w_state_d;
  logic [CntW-1:0]   r_len, w_len_d;
  logic [CntW-1:0]   r_sent, w_sent_d;
  logic [CntW-1:0]   r_pending;
  logic [CntW-1:0]   w_avail;
  logic [15:0]       r_frame_cnt, w_frame_cnt_d;
  logic              r_underrun, w_underrun_d;
  logic              r_overrun, w_overrun_d;
  logic              w_active, w_room, w_batch_full;
  logic              w_tmr_load, w_tmr_en, w_tmr_done;
  logic [TimerW-1:0] w_tmr_val;

  assign w_avail      = CntW'(min_len(32'(i_fifo_count), MaxPayload));
  assign w_batch_full = i_fifo_count >= CntW'(MinBatch);
  assign w_active     = (r_state == StArmed) || (r_state == StSend);
  assign w_room       = r_sent < r_len;
  assign w_tmr_en     = (r_state == StWait) || (r_state == StGap);

  batch_timer #(
    .Width(TimerW)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_en      (w_tmr_en),
    .o_done    (w_tmr_done)
  );

  always_comb begin
    w_state_d     = r_state;
    w_len_d       = r_len;
    w_sent_d      = r_sent;
    w_frame_cnt_d = r_frame_cnt;
    w_underrun_d  = r_underrun;
    w_overrun_d   = r_overrun;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    unique case (r_state)
      StIdle: begin
        if (w_batch_full) begin
          w_len_d   = w_avail;
          w_sent_d  = '0;
          w_state_d = StArmed;
        end else if (i_fifo_count != '0) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TimerW'(TimeoutCycles - 1);
          w_state_d  = StWait;
        end
      end
      StWait: begin
        // An emptied FIFO must win so that len can never latch as zero.
        if (i_fifo_count == '0) begin
          w_state_d = StIdle;
        end else if (w_batch_full || w_tmr_done) begin
          w_len_d   = w_avail;
          w_sent_d  = '0;
          w_state_d = StArmed;
        end
      end
      StArmed, StSend: begin
        if (i_udp_tx_rden) begin
          if (w_room) begin
            // Empty-FIFO requests still count so the frame keeps its announced length.
            w_sent_d = r_sent + 1'b1;
            if (i_fifo_empty) w_underrun_d = 1'b1;
            if (w_sent_d == r_len) begin
              w_frame_cnt_d = r_frame_cnt + 1'b1;
              w_tmr_load    = 1'b1;
              w_tmr_val     = TimerW'(GapCycles - 1);
              w_state_d     = StGap;
            end else begin
              w_state_d = StSend;
            end
          end else begin
            w_overrun_d = 1'b1;
          end
        end
      end
      StGap: begin
        if (w_tmr_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    if (i_udp_tx_rden && !w_active) w_overrun_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_sent      <= '0;
      r_pending   <= '0;
      r_frame_cnt <= '0;
      r_underrun  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_len       <= w_len_d;
      r_sent      <= w_sent_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_underrun  <= w_underrun_d;
      r_overrun   <= w_overrun_d;
      // Announce one cycle after arming; withdraw the cycle after the last byte.
      r_pending   <= (w_active && ((w_state_d == StArmed) || (w_state_d == StSend))) ?
                     r_len : '0;
    end
  end

  assign o_fifo_rd_en          = i_udp_tx_rden && w_active && w_room && !i_fifo_empty;
  assign o_udp_tx_pending_data = r_pending;
  assign o_udp_tx              = i_fifo_dout;
  assign o_busy                = w_active;
  assign o_underrun_err        = r_underrun;
  assign o_overrun_err         = r_overrun;
  assign o_frame_cnt           = r_frame_cnt;

endmodule
